iterative_divider: RTL and testbench



---
 rtl/iterative_divider.sv | 116 +++++++++++
 tb/tb_iterative_divider.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/iterative_divider.sv
// Restoring shift-subtract unsigned divider: one quotient bit per clock, done N+1 cycles after start (1 cycle on divide-by-zero).
// A start is accepted only in IDLE; start while busy or during the done pulse is ignored, and results hold until the next done.
module iterative_divider #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic [3:0]   flags,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state, state_nxt;
   // The partial remainder never reaches B, so its top bit is always zero and is not stored.
   logic [N-1:0]   r, r_nxt;
   logic [N-1:0]   q, q_nxt;
   logic [N-1:0]   b_reg;
   logic [CW-1:0]  cnt;
   logic [N:0]     s, d;
   logic           load_start, load_res, res_ovf;
   logic [N-1:0]   res_q, res_r;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      s = {r, q[N-1]};
      d = s - {1'b0, b_reg};
      if (!d[N]) begin
         r_nxt = d[N-1:0];
         q_nxt = {q[N-2:0], 1'b1};
      end else begin
         r_nxt = s[N-1:0];
         q_nxt = {q[N-2:0], 1'b0};
      end
   end

   always_comb begin
      state_nxt  = state;
      load_start = 1'b0;
      load_res   = 1'b0;
      res_q      = q_nxt;
      res_r      = r_nxt;
      res_ovf    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (B == '0) begin
                  state_nxt = DONE;
                  load_res  = 1'b1;
                  res_q     = '1;
                  res_r     = A;
                  res_ovf   = 1'b1;
               end else begin
                  state_nxt  = CALC;
                  load_start = 1'b1;
               end
            end
         end
         CALC: begin
            busy = 1'b1;
            if (cnt == '0) begin
               state_nxt = DONE;
               load_res  = 1'b1;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r         <= '0;
         q         <= '0;
         b_reg     <= '0;
         cnt       <= '0;
         quotient  <= '0;
         remainder <= '0;
         flags     <= '0;
      end else begin
         if (load_start) begin
            r     <= '0;
            q     <= A;
            b_reg <= B;
            cnt   <= CW'(N - 1);
         end else if (state == CALC) begin
            r   <= r_nxt;
            q   <= q_nxt;
            cnt <= cnt - CW'(1);
         end
         if (load_res) begin
            quotient  <= res_q;
            remainder <= res_r;
            flags     <= {res_q[N-1], res_q == '0, 1'b0, res_ovf};
         end
      end
   end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed and random checks of iterative_divider against a plain-arithmetic division model.
module tb_iterative_divider;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] A, B;
   logic [N-1:0] quotient, remainder;
   logic [3:0]   flags;
   logic         busy, done;

   int n_assert = 0;
   int n_fail   = 0;

   iterative_divider #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
      .quotient(quotient), .remainder(remainder), .flags(flags),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One division from request to the cycle after done. repulse_k>0 re-requests 9/3 on edge t+repulse_k;
   // start_in_done holds a 9/3 request during the done cycle (it must not be taken there).
   task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                          input int repulse_k, input bit start_in_done);
      logic [N-1:0] eq, er;
      logic [3:0]   ef;
      int           lat, cyc, busy_cnt;
      bit           got;
      if (b == 0) begin
         eq  = {N{1'b1}};
         er  = a;
         lat = 1;
      end else begin
         eq  = a / b;
         er  = a % b;
         lat = N + 1;
      end
      ef = {eq[N-1], (eq == 0), 1'b0, (b == 0)};

      A = a; B = b; start = 1'b1;
      step();
      start = 1'b0;
      cyc = 1; busy_cnt = 0; got = 1'b0;
      while (cyc <= N + 4) begin
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
         if (busy === 1'b1) busy_cnt++;
         if (repulse_k > 0 && cyc == repulse_k - 1) begin
            start = 1'b1; A = 9; B = 3;
         end
         step();
         start = 1'b0;
         cyc++;
      end
      chk("done_latency", 64'(got ? cyc : 0), 64'(lat));
      chk("busy_cycles", 64'(busy_cnt), 64'((b == 0) ? 0 : N));
      chk("quotient", 64'(quotient), 64'(eq));
      chk("remainder", 64'(remainder), 64'(er));
      chk("flags", 64'(flags), 64'(ef));
      chk("busy_at_done", 64'(busy), 64'(0));
      if (start_in_done) begin
         start = 1'b1; A = 9; B = 3;
      end
      step();
      start = 1'b0;
      chk("done_one_cycle", 64'(done), 64'(0));
      chk("no_accept_in_done", 64'(busy), 64'(0));
      chk("result_hold", 64'(quotient), 64'(eq));
   endtask

   initial begin
      logic [N-1:0] ra, rb, q0, r0;
      int           sel;
      bit           seen;

      // Reset held with a pending request
      rst = 1'b0; start = 1'b1; A = 100; B = 7;
      step();
      step();
      chk("rst_quotient", 64'(quotient), 64'(0));
      chk("rst_remainder", 64'(remainder), 64'(0));
      chk("rst_flags", 64'(flags), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      rst = 1'b1; start = 1'b0;
      step();
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_done", 64'(done), 64'(0));

      run_div(32'd100, 32'd7, 0, 1'b0);
      run_div(32'd5, 32'd0, 0, 1'b0);
      run_div(32'd3, 32'd10, 0, 1'b0);
      run_div(32'hFFFFFFFF, 32'd1, 0, 1'b0);
      run_div(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
      run_div(32'd0, 32'd9, 0, 1'b0);
      // Request during CALC ignored; request during DONE ignored, then taken in the first IDLE cycle
      run_div(32'd100, 32'd7, 5, 1'b1);
      run_div(32'd9, 32'd3, 0, 1'b0);

      // Reset on edge t+10 of an operation in flight
      A = 100; B = 7; start = 1'b1;
      step();
      start = 1'b0;
      repeat (8) step();
      rst = 1'b0;
      step();
      chk("midrst_quotient", 64'(quotient), 64'(0));
      chk("midrst_remainder", 64'(remainder), 64'(0));
      chk("midrst_flags", 64'(flags), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));
      rst = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < N + 8; i++) begin
         if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
         step();
      end
      chk("midrst_no_done", 64'(seen), 64'(0));

      for (int i = 0; i < 1000; i++) begin
         sel = $urandom_range(0, 9);
         ra  = (sel > 6) ? N'($urandom_range(0, 255)) : N'($urandom);
         if (sel == 0)      rb = '0;
         else if (sel <= 3) rb = N'($urandom_range(1, 15));
         else               rb = N'($urandom);
         run_div(ra, rb, 0, 1'b0);
         if (rb != 0) begin
            q0 = quotient;
            r0 = remainder;
            chk("inv_reconstruct", 64'(q0) * 64'(rb) + 64'(r0), 64'(ra));
            chk("inv_rem_lt_b", 64'(r0 < rb), 64'(1));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
